// File: rtl/otp_ctrl_otp_arb_pkg.sv
// Shared types for the OTP macro command arbiter: macro command/error enums, escalation
// token, interface widths and the latched request record.
package otp_ctrl_otp_arb_pkg;

  localparam int OtpWidth         = 16;
  localparam int OtpSizeWidth     = 2;
  localparam int OtpIfWidth       = (1 << OtpSizeWidth) * OtpWidth;
  localparam int OtpAddrWidth     = 10;
  localparam int ScrmblBlockWidth = 64;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  typedef enum logic [1:0] {
    Read  = 2'b00,
    Write = 2'b01,
    Init  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4
  } err_e;

  typedef struct packed {
    cmd_e                    cmd;
    logic [OtpSizeWidth-1:0] size;
    logic [OtpIfWidth-1:0]   wdata;
    logic [OtpAddrWidth-1:0] addr;
  } otp_arb_req_t;

  // Index width for a value range of n entries; never narrower than one bit.
  function automatic int vbits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/otp_ctrl_arb_rr_pick.sv
// Combinational rotating-priority picker: the first asserted request at or after ptr wins.
module otp_ctrl_arb_rr_pick
  import otp_ctrl_otp_arb_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int IdxWidth = vbits(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic                valid,
  output logic [IdxWidth-1:0] idx
);

  always_comb begin
    logic [IdxWidth-1:0] j;
    j     = '0;
    valid = |req;
    idx   = '0;
    // Walk from farthest to nearest so the closest requester after ptr overwrites last.
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = IdxWidth'((int'(ptr) + i) % NumReq);
      if (req[j]) begin
        idx = j;
      end
    end
  end

endmodule

// File: rtl/otp_ctrl_otp_arb.sv
// Round-robin arbiter for the single OTP macro port; one transaction in flight, grant and
// response routed to the latched winner, permanent lockdown on escalation or bad state.
module otp_ctrl_otp_arb
  import otp_ctrl_otp_arb_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int IdxWidth = vbits(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  lc_tx_t                      escalate_en_i,
  input  logic [NumReq-1:0]           req_i,
  input  cmd_e                        cmd_i   [NumReq],
  input  logic [OtpSizeWidth-1:0]     size_i  [NumReq],
  input  logic [OtpIfWidth-1:0]       wdata_i [NumReq],
  input  logic [OtpAddrWidth-1:0]     addr_i  [NumReq],
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [ScrmblBlockWidth-1:0] rdata_o,
  output err_e                        err_o,
  output logic                        otp_req_o,
  output cmd_e                        otp_cmd_o,
  output logic [OtpSizeWidth-1:0]     otp_size_o,
  output logic [OtpIfWidth-1:0]       otp_wdata_o,
  output logic [OtpAddrWidth-1:0]     otp_addr_o,
  input  logic                        otp_gnt_i,
  input  logic                        otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0] otp_rdata_i,
  input  err_e                        otp_err_i,
  output logic                        fsm_err_o,
  output logic                        idle_o
);

  // Pairwise Hamming distance >= 3 so a single upset lands in the default branch.
  localparam logic [4:0] IdleSt  = 5'b00111;
  localparam logic [4:0] ReqSt   = 5'b11100;
  localparam logic [4:0] RspSt   = 5'b01010;
  localparam logic [4:0] ErrorSt = 5'b10001;

  logic [4:0]          state_d, state_q;
  logic [IdxWidth-1:0] ptr_d, ptr_q, idx_d, idx_q, pick_idx;
  otp_arb_req_t        fields_d, fields_q;
  logic                pick_vld, esc;

  assign esc = (escalate_en_i != Off);

  otp_ctrl_arb_rr_pick #(
    .NumReq  (NumReq),
    .IdxWidth(IdxWidth)
  ) u_pick (
    .req  (req_i),
    .ptr  (ptr_q),
    .valid(pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    fields_d  = fields_q;
    gnt_o     = '0;
    rvalid_o  = '0;
    otp_req_o = 1'b0;
    fsm_err_o = 1'b0;
    idle_o    = 1'b0;
    case (state_q)
      IdleSt: begin
        idle_o = 1'b1;
        if (esc) begin
          state_d   = ErrorSt;
          fsm_err_o = 1'b1;
        end else if (pick_vld) begin
          idx_d          = pick_idx;
          fields_d.cmd   = cmd_i[pick_idx];
          fields_d.size  = size_i[pick_idx];
          fields_d.wdata = wdata_i[pick_idx];
          fields_d.addr  = addr_i[pick_idx];
          state_d        = ReqSt;
        end
      end
      ReqSt: begin
        otp_req_o = 1'b1;
        if (esc) begin
          state_d   = ErrorSt;
          fsm_err_o = 1'b1;
        end else if (otp_gnt_i) begin
          gnt_o[idx_q] = 1'b1;
          state_d      = RspSt;
        end
      end
      RspSt: begin
        // Escalation waits for the outstanding response so the macro handshake completes.
        if (otp_rvalid_i) begin
          rvalid_o[idx_q] = 1'b1;
          ptr_d = (idx_q == IdxWidth'(NumReq - 1)) ? '0 : idx_q + IdxWidth'(1);
          if (esc) begin
            state_d   = ErrorSt;
            fsm_err_o = 1'b1;
          end else begin
            state_d = IdleSt;
          end
        end
      end
      ErrorSt: begin
        state_d = ErrorSt;
      end
      default: begin
        state_d   = ErrorSt;
        fsm_err_o = 1'b1;
      end
    endcase
  end

  assign rdata_o     = (|rvalid_o) ? otp_rdata_i : '0;
  assign err_o       = (|rvalid_o) ? otp_err_i : NoError;
  assign otp_cmd_o   = fields_q.cmd;
  assign otp_size_o  = fields_q.size;
  assign otp_wdata_o = fields_q.wdata;
  assign otp_addr_o  = fields_q.addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IdleSt;
      ptr_q    <= '0;
      idx_q    <= '0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      fields_q <= fields_d;
    end
  end

endmodule

// File: tb/tb_otp_ctrl_otp_arb.sv
// Bench for otp_ctrl_otp_arb: transaction table, directed corner sequences, and a
// randomized run against a transaction-level round-robin reference.
module tb_otp_ctrl_otp_arb;
  import otp_ctrl_otp_arb_pkg::*;

  localparam int N = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  lc_tx_t                      escalate_en_i;
  logic [N-1:0]                req_i;
  cmd_e                        cmd_i   [N];
  logic [OtpSizeWidth-1:0]     size_i  [N];
  logic [OtpIfWidth-1:0]       wdata_i [N];
  logic [OtpAddrWidth-1:0]     addr_i  [N];
  logic [N-1:0]                gnt_o, rvalid_o;
  logic [ScrmblBlockWidth-1:0] rdata_o, otp_rdata_i;
  err_e                        err_o, otp_err_i;
  logic                        otp_req_o;
  cmd_e                        otp_cmd_o;
  logic [OtpSizeWidth-1:0]     otp_size_o;
  logic [OtpIfWidth-1:0]       otp_wdata_o;
  logic [OtpAddrWidth-1:0]     otp_addr_o;
  logic                        otp_gnt_i, otp_rvalid_i, fsm_err_o, idle_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otp_ctrl_otp_arb #(.NumReq(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .escalate_en_i(escalate_en_i),
    .req_i        (req_i),
    .cmd_i        (cmd_i),
    .size_i       (size_i),
    .wdata_i      (wdata_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .otp_req_o    (otp_req_o),
    .otp_cmd_o    (otp_cmd_o),
    .otp_size_o   (otp_size_o),
    .otp_wdata_o  (otp_wdata_o),
    .otp_addr_o   (otp_addr_o),
    .otp_gnt_i    (otp_gnt_i),
    .otp_rvalid_i (otp_rvalid_i),
    .otp_rdata_i  (otp_rdata_i),
    .otp_err_i    (otp_err_i),
    .fsm_err_o    (fsm_err_o),
    .idle_o       (idle_o)
  );

  typedef struct {
    logic [N-1:0]            req;
    cmd_e                    cmd;
    logic [OtpAddrWidth-1:0] addr;
    int                      gnt_dly;
    int                      rv_dly;
    err_e                    err;
    int                      win;
    int                      ptr_after;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_i         = '0;
    escalate_en_i = Off;
    otp_gnt_i     = 1'b0;
    otp_rvalid_i  = 1'b0;
    otp_rdata_i   = '0;
    otp_err_i     = NoError;
    for (int i = 0; i < N; i++) begin
      cmd_i[i]   = Read;
      size_i[i]  = '0;
      wdata_i[i] = '0;
      addr_i[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    for (int i = 0; i < N; i++) begin
      addr_i[i]  = (i == v.win) ? v.addr : v.addr ^ OtpAddrWidth'((i + 1) * 37);
      cmd_i[i]   = (i == v.win) ? v.cmd : Init;
      size_i[i]  = OtpSizeWidth'(i);
      wdata_i[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    req_i = v.req;
    @(negedge clk);
    check("txn_idle", 64'({idle_o, otp_req_o}), 64'(2'b10));
    tick();
    for (int c = 0; c <= v.gnt_dly; c++) begin
      otp_gnt_i = (c == v.gnt_dly);
      @(negedge clk);
      check("txn_otp_req", 64'(otp_req_o), 64'(1));
      check("txn_addr", 64'(otp_addr_o), 64'(v.addr));
      check("txn_cmd", 64'(otp_cmd_o), 64'(v.cmd));
      if (c == 0) begin
        check("txn_size", 64'(otp_size_o), 64'(v.win));
        check("txn_wdata", 64'(otp_wdata_o), 64'hA5A5_0000_0000_0000 | 64'(v.win));
      end
      check("txn_gnt", 64'(gnt_o), otp_gnt_i ? 64'(onehot(v.win)) : 64'(0));
      tick();
    end
    otp_gnt_i = 1'b0;
    req_i     = '0;
    for (int c = 0; c <= v.rv_dly; c++) begin
      otp_rvalid_i = (c == v.rv_dly);
      otp_err_i    = v.err;
      otp_rdata_i  = {$urandom, $urandom};
      @(negedge clk);
      check("txn_rvalid", 64'(rvalid_o), otp_rvalid_i ? 64'(onehot(v.win)) : 64'(0));
      if (otp_rvalid_i) begin
        check("txn_err", 64'(err_o), 64'(v.err));
        check("txn_rdata", rdata_o, otp_rdata_i);
      end
      tick();
    end
    otp_rvalid_i = 1'b0;
    check("txn_ptr", 64'(dut.ptr_q), 64'(v.ptr_after));
  endtask

  initial begin
    int order[$];
    bit inflight;
    int g, pulses, ncomp, m_stage, m_next, m_ptr, m_idx, best, bestd, d;
    cmd_e m_cmd;
    logic [OtpSizeWidth-1:0] m_size;
    logic [OtpIfWidth-1:0] m_wdata;
    logic [OtpAddrWidth-1:0] m_addr;
    logic [N-1:0] exp_gnt, exp_rv;
    logic exp_idle, exp_req;

    vecs[0] = '{req: 4'b0100, cmd: Write, addr: 10'h1A0, gnt_dly: 1, rv_dly: 2, err: NoError,              win: 2, ptr_after: 3};
    vecs[1] = '{req: 4'b1111, cmd: Read,  addr: 10'h055, gnt_dly: 0, rv_dly: 0, err: MacroEccCorrError,    win: 3, ptr_after: 0};
    vecs[2] = '{req: 4'b0110, cmd: Write, addr: 10'h3FF, gnt_dly: 2, rv_dly: 1, err: NoError,              win: 1, ptr_after: 2};
    vecs[3] = '{req: 4'b0011, cmd: Init,  addr: 10'h000, gnt_dly: 0, rv_dly: 3, err: MacroError,           win: 0, ptr_after: 1};
    vecs[4] = '{req: 4'b1001, cmd: Read,  addr: 10'h123, gnt_dly: 1, rv_dly: 0, err: MacroEccUncorrError,  win: 3, ptr_after: 0};
    vecs[5] = '{req: 4'b1000, cmd: Write, addr: 10'h2AA, gnt_dly: 0, rv_dly: 1, err: NoError,              win: 3, ptr_after: 0};
    vecs[6] = '{req: 4'b0001, cmd: Read,  addr: 10'h001, gnt_dly: 0, rv_dly: 0, err: MacroWriteBlankError, win: 0, ptr_after: 1};
    vecs[7] = '{req: 4'b1101, cmd: Write, addr: 10'h155, gnt_dly: 3, rv_dly: 2, err: NoError,              win: 2, ptr_after: 3};

    // Reset state
    rst = 1'b1;
    req_i = '0; escalate_en_i = Off; otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0;
    otp_rdata_i = '0; otp_err_i = NoError;
    for (int i = 0; i < N; i++) begin
      cmd_i[i] = Read; size_i[i] = '0; wdata_i[i] = '0; addr_i[i] = '0;
    end
    @(negedge clk);
    check("rst_idle", 64'(idle_o), 64'(1));
    check("rst_ctl", 64'({otp_req_o, fsm_err_o, gnt_o, rvalid_o}), 64'(0));
    check("rst_cmd", 64'(otp_cmd_o), 64'(Read));
    check("rst_addr", 64'(otp_addr_o), 64'(0));
    check("rst_rdata", rdata_o, 64'(0));
    check("rst_ptr", 64'(dut.ptr_q), 64'(0));
    do_reset();

    for (int k = 0; k < 8; k++) run_txn(vecs[k]);

    // Fairness with all requesters continuously asserted
    do_reset();
    req_i = '1;
    inflight = 1'b0;
    for (int c = 0; c < 200 && order.size() < 8; c++) begin
      otp_gnt_i    = otp_req_o;
      otp_rvalid_i = inflight;
      @(negedge clk);
      if (|gnt_o) begin
        g = -1;
        for (int i = 0; i < N; i++) if (gnt_o == onehot(i)) g = i;
        order.push_back(g);
        inflight = 1'b1;
      end else if (|rvalid_o) begin
        inflight = 1'b0;
      end
      tick();
    end
    check("fair_count", 64'(order.size()), 64'(8));
    for (int k = 0; k < order.size(); k++) check("fair_order", 64'(order[k]), 64'(k % N));
    req_i = '0; otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0;
    repeat (3) tick();

    // Field latching: winner changes addr and drops req right after arbitration
    do_reset();
    addr_i[1] = 10'h2B3; cmd_i[1] = Write; req_i = 4'b0010;
    tick();
    addr_i[1] = 10'h0CC; req_i = '0;
    for (int c = 0; c <= 2; c++) begin
      otp_gnt_i = (c == 2);
      @(negedge clk);
      check("latch_req", 64'(otp_req_o), 64'(1));
      check("latch_addr", 64'(otp_addr_o), 64'h2B3);
      check("latch_gnt", 64'(gnt_o), (c == 2) ? 64'(4'b0010) : 64'(0));
      tick();
    end
    otp_gnt_i = 1'b0; otp_rvalid_i = 1'b1;
    @(negedge clk);
    check("latch_rvalid", 64'(rvalid_o), 64'(4'b0010));
    tick();
    otp_rvalid_i = 1'b0;
    @(negedge clk);
    check("latch_back_idle", 64'({idle_o, otp_req_o}), 64'(2'b10));

    // Escalation during RspSt
    tick();
    req_i = 4'b0001;
    tick();
    otp_gnt_i = 1'b1;
    @(negedge clk);
    check("esc_gnt", 64'(gnt_o), 64'(4'b0001));
    tick();
    otp_gnt_i = 1'b0; req_i = '0; escalate_en_i = On;
    @(negedge clk);
    check("esc_wait_rsp", 64'({rvalid_o, fsm_err_o}), 64'(0));
    tick();
    otp_rvalid_i = 1'b1;
    @(negedge clk);
    check("esc_rvalid", 64'(rvalid_o), 64'(4'b0001));
    check("esc_fsm_err", 64'(fsm_err_o), 64'(1));
    tick();
    otp_rvalid_i = 1'b0; req_i = '1; otp_gnt_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) escalate_en_i = Off;
      @(negedge clk);
      check("esc_locked", 64'({idle_o, otp_req_o, gnt_o}), 64'(0));
      pulses += int'(fsm_err_o);
      tick();
    end
    check("esc_extra_pulse", 64'(pulses), 64'(0));

    // Invalid state encoding
    do_reset();
    force dut.state_q = 5'b11111;
    @(negedge clk);
    check("bad_fsm_err", 64'(fsm_err_o), 64'(1));
    check("bad_idle", 64'(idle_o), 64'(0));
    tick();
    release dut.state_q;
    req_i = '1; otp_gnt_i = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bad_locked", 64'({fsm_err_o, idle_o, otp_req_o, gnt_o}), 64'(0));
      tick();
    end

    // Randomized traffic against a transaction-level reference
    do_reset();
    m_stage = 0; m_ptr = 0; m_idx = 0; ncomp = 0;
    m_cmd = Read; m_size = '0; m_wdata = '0; m_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ((req_i & onehot(i)) == '0 && $urandom_range(0, 2) == 0) begin
          req_i = req_i | onehot(i);
          case ($urandom_range(0, 2))
            0:       cmd_i[i] = Read;
            1:       cmd_i[i] = Write;
            default: cmd_i[i] = Init;
          endcase
          size_i[i]  = OtpSizeWidth'($urandom);
          wdata_i[i] = {$urandom, $urandom};
          addr_i[i]  = OtpAddrWidth'($urandom);
        end
      end
      otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0;
      if (m_stage == 0) begin
        otp_gnt_i = ($urandom_range(0, 3) == 0);
        otp_rvalid_i = ($urandom_range(0, 3) == 0);
      end else if (m_stage == 1) begin
        otp_gnt_i = ($urandom_range(0, 1) == 1);
      end else begin
        otp_rvalid_i = ($urandom_range(0, 2) == 0);
        otp_gnt_i = ($urandom_range(0, 3) == 0);
      end
      otp_rdata_i = {$urandom, $urandom};
      otp_err_i   = err_e'(3'($urandom_range(0, 4)));
      @(negedge clk);
      exp_gnt = '0; exp_rv = '0;
      exp_idle = (m_stage == 0); exp_req = (m_stage == 1);
      m_next = m_stage;
      if (m_stage == 0) begin
        if (req_i != '0) begin
          best = -1; bestd = N;
          for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if ((req_i & onehot(i)) != '0 && d < bestd) begin
              bestd = d; best = i;
            end
          end
          m_idx = best; m_cmd = cmd_i[best]; m_size = size_i[best];
          m_wdata = wdata_i[best]; m_addr = addr_i[best];
          m_next = 1;
        end
      end else if (m_stage == 1) begin
        check("rnd_fields", 64'({otp_cmd_o, otp_size_o, otp_addr_o}), 64'({m_cmd, m_size, m_addr}));
        check("rnd_wdata", otp_wdata_o, m_wdata);
        if (otp_gnt_i) begin
          exp_gnt = onehot(m_idx); m_next = 2;
        end
      end else if (otp_rvalid_i) begin
        exp_rv = onehot(m_idx);
        m_ptr = (m_idx + 1) % N;
        m_next = 0;
        ncomp++;
        check("rnd_rdata", rdata_o, otp_rdata_i);
        check("rnd_err", 64'(err_o), 64'(otp_err_i));
      end
      check("rnd_ctl", 64'({idle_o, otp_req_o, fsm_err_o, gnt_o, rvalid_o}),
            64'({exp_idle, exp_req, 1'b0, exp_gnt, exp_rv}));
      tick();
      req_i = req_i & ~exp_gnt;
      m_stage = m_next;
    end
    check("rnd_progress", 64'(ncomp > 100), 64'(1));
    check("rnd_ptr", 64'(dut.ptr_q), 64'(m_ptr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
